risc8_bus_arb: RTL and testbench
================================

# risc8_bus_arb

- Arbitrates the single external memory bus of the risc8 core between two masters: the CPU bus interface and a DMA requester.
- Sits between the risc8 top-level bus pins (`cycle`/`write`/`address`/`data_out`/`data_in`/`ready`) and the memory/peripheral fabric.
- Arbitration is fair: alternating grant under contention.
- A per-transfer watchdog terminates hung transfers with an error pulse.

## Interface
- `TIMEOUT`, default 15: max transfer cycles before forced termination; legal range 2..255.
- `ERR_DATA`, default 8'hFF: read data returned on a timed-out transfer.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: reset; one clock, asynchronous, active-low.
- `cpu_cycle`, `cpu_write` input 1 each: CPU bus cycle request and direction.
- `cpu_address` input 16, `cpu_data_out` input 8: CPU address and write data.
- `cpu_data_in` output 8: read data to the CPU.
- `cpu_ready` output 1: CPU transfer-complete strobe.
- `dma_req`, `dma_write` input 1 each: DMA request and direction.
- `dma_address` input 16, `dma_wdata` input 8: DMA address and write data.
- `dma_gnt` output 1: DMA owns the bus.
- `dma_ready` output 1: DMA transfer-complete strobe.
- `dma_rdata` output 8: read data to the DMA.
- `mem_cycle`, `mem_write` output 1 each: memory-side bus cycle and direction.
- `mem_address` output 16, `mem_wdata` output 8: memory-side address and write data.
- `mem_rdata` input 8: memory read data.
- `mem_ready` input 1: memory completion.
- `bus_err` output 1: one-cycle pulse on timeout.
- `err_addr` output 16: address of the last timed-out transfer.

## Operation
- Requester protocol: the master holds its request, address, write and data stable until it samples its ready high on a clock edge. Ready is a single-cycle strobe.
- States are IDLE, CPU_XFER and DMA_XFER, plus a `last_dma` bit recording the last owner.
- IDLE transitions:
  - Only `cpu_cycle` high: go to CPU_XFER.
  - Only `dma_req` high: go to DMA_XFER.
  - Both high: grant the master not served last. `last_dma`=1 → CPU; `last_dma`=0 → DMA.
  - Neither high: stay in IDLE.
- In an XFER state:
  - `mem_cycle`=1; `mem_write`, `mem_address` and `mem_wdata` mux from the owner; `dma_gnt`=1 in DMA_XFER.
- Normal completion: `mem_ready`=1 in an XFER cycle.
  - Owner's ready=1 that cycle, read data = `mem_rdata`.
  - Next state IDLE; `last_dma` updated.
- Timeout: the XFER cycle counter runs 1..`TIMEOUT`. On cycle `TIMEOUT` with `mem_ready`=0:
  - Owner's ready=1 with read data `ERR_DATA`; `bus_err`=1 for that cycle.
  - `err_addr` is loaded with `mem_address` at that edge; next state IDLE.
  - `mem_ready` high on cycle `TIMEOUT` counts as a normal completion, not a timeout.
- Mandatory IDLE cycle after every transfer. This ensures a master still holding its request on the completion edge is never regranted for a stale cycle.
- Requests arriving during another master's transfer wait; they are not lost because requesters hold their request.
- Requester deasserting its request mid-transfer is illegal; the arbiter keeps its state and completes normally or by timeout.
- `mem_ready` while in IDLE is ignored.
- Outputs in IDLE: non-owner read data is 0, ready is 0, all `mem_*` outputs are 0.

## Timing
- Reset (asynchronous, any time including mid-transfer):
  - State → IDLE, `last_dma` → 1 so the CPU wins the first contention, counter → 0, `err_addr` → 0.
  - All outputs read 0: `mem_cycle`, `mem_write`, `mem_address`, `mem_wdata`, `cpu_ready`, `cpu_data_in`, `dma_gnt`, `dma_ready`, `dma_rdata`, `bus_err`.
- Arbitration latency is 1 cycle: request seen in IDLE at edge N → `mem_cycle` high in cycle N+1.
- Transfer length is 1 + W cycles for W memory wait states; bus occupancy is 2 + W cycles including IDLE.
- All outputs are combinational from registered state and current inputs; no input-to-output path exists in IDLE. Ready/data pass through from `mem_ready`/`mem_rdata` in the same cycle.
- Counter width is 8 bits. It saturates at `TIMEOUT`, clears on entering IDLE, and cannot wrap.

## Structure
- Package `risc8_bus_pkg` holds:
  - state encoding: IDLE=2'b00, CPU_XFER=2'b01, DMA_XFER=2'b10;
  - owner constants;
  - default `ERR_DATA`.
- Sub-module `risc8_bus_timer` is the timeout counter.
  - Inputs: `clk`, `rst_n`, `run`, `clear`.
  - Output: `expired`, high when count = `TIMEOUT`.
- Top holds the FSM, the `last_dma` bit, the muxes and `err_addr`.

## Test plan
- CPU read at 16'h1234, `mem_ready` after 2 wait states with `mem_rdata`=8'h5A → `cpu_ready` pulses in the 3rd XFER cycle with `cpu_data_in`=8'h5A; `mem_cycle` high for exactly 3 cycles.
- DMA write to 16'h8000 with data 8'hC3, zero wait → `dma_gnt` and `mem_write` high 1 cycle with `mem_wdata`=8'hC3; `dma_ready` pulses.
- `cpu_cycle` and `dma_req` held together after reset, zero wait → grants go CPU, DMA, CPU, DMA; one IDLE cycle between each.
- CPU read of 16'hDEAD, `mem_ready` never asserted, default `TIMEOUT` → on XFER cycle 15: `cpu_ready`=1, `cpu_data_in`=8'hFF, `bus_err` pulses, `err_addr`=16'hDEAD.
- `dma_req` rises during a CPU transfer with 4 wait states → DMA is granted exactly 2 cycles after `cpu_ready`.
- `rst_n` low during DMA_XFER wait → all outputs 0 immediately. After release, simultaneous requests grant the CPU first.

Source files
------------

// File: rtl/risc8_bus_pkg.sv
// rtl/risc8_bus_pkg.sv - shared types and constants for the risc8 bus arbiter
package risc8_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CPU_XFER = 2'b01,
        DMA_XFER = 2'b10
    } bus_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;
    localparam int         TIMEOUT_DEFAULT  = 15;

endpackage

// File: rtl/risc8_bus_timer.sv
// rtl/risc8_bus_timer.sv - per-transfer watchdog counter, saturating at TIMEOUT
module risc8_bus_timer
    import risc8_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count;

    // Count reads k during the k-th transfer cycle because it steps on the
    // same edge that enters the transfer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (run && (count != LIMIT)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/risc8_bus_arb.sv
// rtl/risc8_bus_arb.sv - fair CPU/DMA arbiter for the risc8 external memory bus
module risc8_bus_arb
    import risc8_bus_pkg::*;
#(
    parameter int         TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [7:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_cycle,
    input  logic        cpu_write,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic        dma_write,
    input  logic [15:0] dma_address,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic        dma_ready,
    output logic [7:0]  dma_rdata,
    output logic        mem_cycle,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err,
    output logic [15:0] err_addr
);

    bus_state_t state, state_d;
    logic       last_dma;
    logic       expired;
    logic       done;
    logic       timeout;
    logic [7:0] rd_data;
    logic       timer_run;
    logic       timer_clear;

    risc8_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (timer_run),
        .clear   (timer_clear),
        .expired (expired)
    );

    assign timer_clear = (state_d == IDLE);
    assign timer_run   = !timer_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_dma <= OWNER_DMA;
            err_addr <= 16'h0000;
        end else begin
            state <= state_d;
            if (done) begin
                last_dma <= (state == DMA_XFER) ? OWNER_DMA : OWNER_CPU;
            end
            if (timeout) begin
                err_addr <= mem_address;
            end
        end
    end

    // Every completion returns to IDLE, so a master still holding its
    // request on the completion edge is re-arbitrated rather than regranted.
    always_comb begin
        state_d     = state;
        done        = 1'b0;
        timeout     = 1'b0;
        rd_data     = 8'h00;
        mem_cycle   = 1'b0;
        mem_write   = 1'b0;
        mem_address = 16'h0000;
        mem_wdata   = 8'h00;
        cpu_ready   = 1'b0;
        cpu_data_in = 8'h00;
        dma_gnt     = 1'b0;
        dma_ready   = 1'b0;
        dma_rdata   = 8'h00;
        bus_err     = 1'b0;

        if (state != IDLE) begin
            done    = mem_ready || expired;
            timeout = expired && !mem_ready;
            rd_data = timeout ? ERR_DATA : mem_rdata;
            bus_err = timeout;
        end

        case (state)
            IDLE: begin
                if (cpu_cycle && dma_req) begin
                    state_d = last_dma ? CPU_XFER : DMA_XFER;
                end else if (cpu_cycle) begin
                    state_d = CPU_XFER;
                end else if (dma_req) begin
                    state_d = DMA_XFER;
                end
            end
            CPU_XFER: begin
                mem_cycle   = 1'b1;
                mem_write   = cpu_write;
                mem_address = cpu_address;
                mem_wdata   = cpu_data_out;
                cpu_ready   = done;
                cpu_data_in = rd_data;
                if (done) begin
                    state_d = IDLE;
                end
            end
            DMA_XFER: begin
                mem_cycle   = 1'b1;
                mem_write   = dma_write;
                mem_address = dma_address;
                mem_wdata   = dma_wdata;
                dma_gnt     = 1'b1;
                dma_ready   = done;
                dma_rdata   = rd_data;
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_risc8_bus_arb.sv
// tb/tb_risc8_bus_arb.sv - directed self-checking bench for risc8_bus_arb
module tb_risc8_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_cycle, cpu_write;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in;
    logic        cpu_ready;
    logic        dma_req, dma_write;
    logic [15:0] dma_address;
    logic [7:0]  dma_wdata;
    logic        dma_gnt, dma_ready;
    logic [7:0]  dma_rdata;
    logic        mem_cycle, mem_write;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        bus_err;
    logic [15:0] err_addr;
    logic [45:0] all_out;

    int total = 0;
    int bad = 0;

    risc8_bus_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_cycle    (cpu_cycle),
        .cpu_write    (cpu_write),
        .cpu_address  (cpu_address),
        .cpu_data_out (cpu_data_out),
        .cpu_data_in  (cpu_data_in),
        .cpu_ready    (cpu_ready),
        .dma_req      (dma_req),
        .dma_write    (dma_write),
        .dma_address  (dma_address),
        .dma_wdata    (dma_wdata),
        .dma_gnt      (dma_gnt),
        .dma_ready    (dma_ready),
        .dma_rdata    (dma_rdata),
        .mem_cycle    (mem_cycle),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .bus_err      (bus_err),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    assign all_out = {mem_cycle, mem_write, mem_address, mem_wdata, cpu_ready,
                      cpu_data_in, dma_gnt, dma_ready, dma_rdata, bus_err};

    task automatic clear_inputs();
        cpu_cycle = 0; cpu_write = 0; cpu_address = 16'h0; cpu_data_out = 8'h0;
        dma_req = 0; dma_write = 0; dma_address = 16'h0; dma_wdata = 8'h0;
        mem_rdata = 8'h0; mem_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        cpu_cycle = 1; dma_req = 1; mem_ready = 1; mem_rdata = 8'hAA;
        cpu_address = 16'h1357; dma_address = 16'h2468;
        @(negedge clk); #1;
        total++;
        if (all_out !== 46'h0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", all_out);
        end
        total++;
        if (err_addr !== 16'h0) begin
            bad++; $display("FAIL reset_err_addr got=%h want=0000", err_addr);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_cpu_read();
        int n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cpu_cycle = (i <= 3); cpu_write = 0; cpu_address = 16'h1234;
            mem_ready = (i == 3); mem_rdata = 8'h5A;
            #1;
            if (mem_cycle) n++;
            total++;
            if (cpu_ready !== (i == 3)) begin
                bad++; $display("FAIL cpu_read_ready i=%0d got=%b want=%b", i, cpu_ready, (i == 3));
            end
            if (mem_cycle) begin
                total++;
                if (mem_address !== 16'h1234 || mem_write !== 1'b0) begin
                    bad++; $display("FAIL cpu_read_addr i=%0d got=%h/%b want=1234/0", i, mem_address, mem_write);
                end
            end
            if (i == 0) begin
                total++;
                if (cpu_data_in !== 8'h00) begin
                    bad++; $display("FAIL cpu_read_idle_data got=%h want=00", cpu_data_in);
                end
            end
            if (i == 3) begin
                total++;
                if (cpu_data_in !== 8'h5A) begin
                    bad++; $display("FAIL cpu_read_data got=%h want=5a", cpu_data_in);
                end
            end
        end
        total++;
        if (n != 3) begin
            bad++; $display("FAIL cpu_read_len got=%0d want=3", n);
        end
        clear_inputs();
    endtask

    task automatic test_dma_write();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dma_req = (i <= 1); dma_write = (i <= 1); dma_address = 16'h8000;
            dma_wdata = 8'hC3; mem_ready = (i == 1);
            #1;
            total++;
            if (dma_gnt !== (i == 1) || mem_write !== (i == 1) || dma_ready !== (i == 1)) begin
                bad++; $display("FAIL dma_write_strobes i=%0d got=%b%b%b want=%b", i, dma_gnt, mem_write, dma_ready, (i == 1));
            end
            if (i == 1) begin
                total++;
                if (mem_wdata !== 8'hC3 || mem_address !== 16'h8000) begin
                    bad++; $display("FAIL dma_write_data got=%h/%h want=c3/8000", mem_wdata, mem_address);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_fairness();
        logic exp_cpu, exp_dma;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cpu_cycle = (i < 8); dma_req = (i < 8);
            cpu_address = 16'h1111; dma_address = 16'h2222; mem_ready = 1;
            #1;
            exp_cpu = (i == 1) || (i == 5);
            exp_dma = (i == 3) || (i == 7);
            total++;
            if (mem_cycle !== (exp_cpu || exp_dma) || dma_gnt !== exp_dma ||
                cpu_ready !== exp_cpu || dma_ready !== exp_dma) begin
                bad++; $display("FAIL fair_grant i=%0d got cyc=%b gnt=%b crdy=%b drdy=%b want cpu=%b dma=%b",
                                i, mem_cycle, dma_gnt, cpu_ready, dma_ready, exp_cpu, exp_dma);
            end
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            cpu_cycle = (i <= 15); cpu_address = 16'hDEAD; mem_ready = 0; mem_rdata = 8'h12;
            #1;
            total++;
            if (bus_err !== (i == 15) || cpu_ready !== (i == 15) ||
                mem_cycle !== (i >= 1 && i <= 15)) begin
                bad++; $display("FAIL timeout_strobes i=%0d got err=%b rdy=%b cyc=%b", i, bus_err, cpu_ready, mem_cycle);
            end
            if (i == 14) begin
                total++;
                if (err_addr !== 16'h0000) begin
                    bad++; $display("FAIL timeout_early_addr got=%h want=0000", err_addr);
                end
            end
            if (i == 15) begin
                total++;
                if (cpu_data_in !== 8'hFF) begin
                    bad++; $display("FAIL timeout_data got=%h want=ff", cpu_data_in);
                end
            end
            if (i == 16) begin
                total++;
                if (err_addr !== 16'hDEAD) begin
                    bad++; $display("FAIL timeout_err_addr got=%h want=dead", err_addr);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_late_ready();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            cpu_cycle = (i <= 15); cpu_address = 16'h0F0F;
            mem_ready = (i == 15); mem_rdata = 8'h3C;
            #1;
            if (i == 15) begin
                total++;
                if (cpu_ready !== 1'b1 || cpu_data_in !== 8'h3C || bus_err !== 1'b0) begin
                    bad++; $display("FAIL late_ready got rdy=%b data=%h err=%b want 1/3c/0", cpu_ready, cpu_data_in, bus_err);
                end
            end
            if (i == 16) begin
                total++;
                if (err_addr !== 16'hDEAD || mem_cycle !== 1'b0) begin
                    bad++; $display("FAIL late_ready_after got addr=%h cyc=%b want dead/0", err_addr, mem_cycle);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_dma_wait();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cpu_cycle = (i <= 5); cpu_address = 16'h4444;
            dma_req = (i >= 2 && i <= 7); dma_address = 16'h5555;
            mem_ready = (i == 5) || (i == 7); mem_rdata = 8'h77;
            #1;
            total++;
            if (cpu_ready !== (i == 5) || dma_gnt !== (i == 7) || dma_ready !== (i == 7) ||
                mem_cycle !== ((i >= 1 && i <= 5) || i == 7)) begin
                bad++; $display("FAIL dma_wait i=%0d got crdy=%b gnt=%b drdy=%b cyc=%b", i, cpu_ready, dma_gnt, dma_ready, mem_cycle);
            end
            if (i == 7) begin
                total++;
                if (dma_rdata !== 8'h77 || mem_address !== 16'h5555 || cpu_data_in !== 8'h00) begin
                    bad++; $display("FAIL dma_wait_data got=%h/%h/%h want 77/5555/00", dma_rdata, mem_address, cpu_data_in);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cpu_cycle = (i <= 1); cpu_address = 16'h0101; mem_ready = (i == 1);
        end
        clear_inputs();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            dma_req = 1; dma_address = 16'h6666; dma_write = 1; dma_wdata = 8'h99;
            #1;
        end
        total++;
        if (dma_gnt !== 1'b1) begin
            bad++; $display("FAIL reset_mid_pre got gnt=%b want=1", dma_gnt);
        end
        mem_ready = 1; mem_rdata = 8'h55;
        rst_n = 0;
        #1;
        total++;
        if (all_out !== 46'h0) begin
            bad++; $display("FAIL reset_mid_outputs got=%h want=0", all_out);
        end
        @(negedge clk);
        mem_ready = 0; cpu_cycle = 1; cpu_address = 16'h7777; rst_n = 1;
        @(negedge clk); #1;
        total++;
        if (mem_cycle !== 1'b1 || dma_gnt !== 1'b0 || mem_address !== 16'h7777) begin
            bad++; $display("FAIL reset_mid_first_grant got cyc=%b gnt=%b addr=%h want 1/0/7777", mem_cycle, dma_gnt, mem_address);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_fairness();
        test_timeout();
        test_late_ready();
        test_dma_wait();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
